dcache_ctrl: RTL
================

# dcache_ctrl

Direct-mapped, write-back data cache controller serving the pipeline's MEM stage. It is the producer of `block_pipe_data_cache`. It accepts load and store requests (`MEM_R_EN`/`MEM_W_EN`, byte or word), answers hits in the same cycle, and raises the stall while it runs line write-back and fill transactions against main memory over a req/ready handshake.

## Interface
- `NUM_LINES`, default 4: number of cache lines; power of two, at least 2.
- `LINE_BYTES`, default 16: bytes per line; fixed at 16, so lines are 128 bits.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `mem_r_en`  in  1  load request from the MEM stage.
- `mem_w_en`  in  1  store request from the MEM stage.
- `is_byte`  in  1  1 = loadb/storeb, 0 = loadw/storew.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data; a byte store uses `wdata[7:0]`.
- `rdata`  out  32  load data; a byte load is zero-extended.
- `block_pipe_data_cache`  out  1  stall request to the pipeline control.
- `mem_req`  out  1  memory transaction request.
- `mem_we`  out  1  1 = line write-back, 0 = line fill.
- `mem_addr`  out  32  line-aligned address; `[3:0]` is always 0.
- `mem_wline`  out  128  victim line data for a write-back.
- `mem_rline`  in  128  fill data; valid in the cycle `mem_ready` is high.
- `mem_ready`  in  1  memory completes the current transaction.

## Operation
- Address split: offset `addr[3:0]`, index `addr[3+log2(NUM_LINES):4]`, tag is the remaining upper bits.
- Word accesses ignore `addr[1:0]`.
- Per line: valid, dirty, tag, 128-bit data.
- Access = `mem_r_en | mem_w_en`. If both are high, the access is a store, and `rdata` returns the pre-write word.
- Hit = valid and tag match.
- FSM states:
  - IDLE: on an access that misses, go to WB if the victim is valid and dirty, otherwise go to FILL. A hit or no access stays in IDLE.
  - WB: `mem_req=1`, `mem_we=1`, `mem_addr={victim tag, index, 4'b0}`, `mem_wline`=victim data. On `mem_ready`, clear the victim's dirty bit and go to FILL.
  - FILL: `mem_req=1`, `mem_we=0`, `mem_addr={addr[31:4], 4'b0}`. On `mem_ready`, write `mem_rline`, set valid, load tag, clear dirty, and go to IDLE.
- In IDLE, the access re-looks-up and now hits. A store then merges its byte or word into the line and sets dirty.
- Store hit: data is written at the clock edge and dirty is set. A byte store updates only lane `addr[3:0]`.
- Load hit: `rdata` is combinational from the line. Otherwise `rdata` = 0.

## Timing
- `block_pipe_data_cache = access & (state != IDLE | !hit)`. It is combinational from the inputs and state.
- The pipeline holds `addr`, `wdata` and the enables stable while stalled.
- Hit latency is 0 cycles, with no stall.
- Clean miss: stall in the lookup cycle, plus the FILL cycles through the `mem_ready` cycle. The stall drops in the next IDLE cycle, where the access hits.
- Dirty miss: WB then FILL, each lasting until its `mem_ready`.
- Handshake:
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wline` are stable from assertion until the cycle `mem_ready` is sampled high.
  - `mem_req` stays high in consecutive WB→FILL cycles; `mem_we` and `mem_addr` change in the first FILL cycle.
  - `mem_ready` is ignored while `mem_req` is 0.
  - `mem_ready` in the same cycle `mem_req` first rises completes the transaction, giving a 1-cycle transaction.
- Reset values:
  - State is IDLE.
  - All valid and dirty bits are 0; tag and data are don't-care.
  - `mem_req=0`, `mem_we=0`, `mem_addr=0`.
  - `block_pipe_data_cache` follows the formula: with state IDLE and all lines invalid, any access stalls.
- Reset mid-transaction aborts the transaction: `mem_req` is 0 in the cycle after reset is sampled, and the line is not installed. Memory must tolerate an abandoned request.
- Access deasserted mid-miss (only possible on a flush): the FSM still completes the current transaction, then returns to IDLE.

## Structure
- Package `dcache_pkg`:
  - state enum {IDLE, WB, FILL}
  - `LINE_W=128`, `OFFSET_W=4`
  - functions `get_index`/`get_tag`, parameterised by `NUM_LINES`
  - byte-lane merge function `merge_store(line, offset, wdata, is_byte)`
- Sub-module `dcache_line_store`: tag, valid, dirty and data arrays.
  - Combinational read port by index.
  - One synchronous write port: full line for a fill; merged line plus dirty bit for a store; dirty clear for a write-back.
  - Valid/dirty clear on reset.
- The FSM and hit logic live in `dcache_ctrl`.

## Test plan
- After reset, loadw 0x100 with memory returning `mem_ready` 3 cycles later (line 0x00000004_00000003_00000002_00000001) → stall for 4 cycles; `mem_addr`=0x100, `mem_we`=0; next cycle no stall, `rdata`=0x00000001.
- Loadb 0x105 following the fill above → no stall, `rdata`=0x00000000. Loadw 0x10C → `rdata`=0x00000004.
- Storeb 0x101 `wdata`=0xAB → no stall, line dirty. Loadw 0x100 → 0x0000AB01.
- Loadw 0x140 (same index 0, different tag) after the dirty store → WB with `mem_addr`=0x100, `mem_we`=1, `mem_wline` word0=0x0000AB01; then FILL with `mem_addr`=0x140; stall drops after the fill.
- Reset asserted during FILL → `mem_req`=0 next cycle. Loadw 0x100 misses again.
- `mem_r_en` and `mem_w_en` both high on a hit, storew 0x108 `wdata`=0xDEADBEEF → `rdata` = old word. A following load returns 0xDEADBEEF.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped write-back data cache:
// FSM state, line geometry, address split and store byte-lane merge.
package dcache_pkg;

  typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

  localparam int LINE_W   = 128;
  localparam int OFFSET_W = 4;

  function automatic logic [31:0] get_index(input logic [31:0] addr, input int num_lines);
    return (addr >> OFFSET_W) & 32'(num_lines - 1);
  endfunction

  function automatic logic [31:0] get_tag(input logic [31:0] addr, input int num_lines);
    return addr >> (OFFSET_W + $clog2(num_lines));
  endfunction

  // A byte store replaces one lane; a word store replaces the aligned word.
  function automatic logic [LINE_W-1:0] merge_store(input logic [LINE_W-1:0] line,
                                                    input logic [OFFSET_W-1:0] offset,
                                                    input logic [31:0] wdata,
                                                    input logic is_byte);
    logic [LINE_W-1:0] merged;
    merged = line;
    if (is_byte)
      merged[{offset, 3'b000} +: 8] = wdata[7:0];
    else
      merged[{offset[3:2], 5'b00000} +: 32] = wdata;
    return merged;
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Tag/valid/dirty/data arrays of the cache: combinational read by index and
// a single synchronous write port shared by fill, store and write-back clean.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 4,
  parameter int IDX_W     = $clog2(NUM_LINES),
  parameter int TAG_W     = 32 - OFFSET_W - IDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  index,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_data,
  input  logic              fill_en,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [LINE_W-1:0] fill_data,
  input  logic              store_en,
  input  logic [LINE_W-1:0] store_data,
  input  logic              clean_en
);

  logic [NUM_LINES-1:0] valid;
  logic [NUM_LINES-1:0] dirty;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [LINE_W-1:0]    data_mem [NUM_LINES];

  assign rd_valid = valid[index];
  assign rd_dirty = dirty[index];
  assign rd_tag   = tag_mem[index];
  assign rd_data  = data_mem[index];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_en) begin
      valid[index] <= 1'b1;
      dirty[index] <= 1'b0;
    end else if (store_en) begin
      dirty[index] <= 1'b1;
    end else if (clean_en) begin
      dirty[index] <= 1'b0;
    end
  end

  // Tag and data need no reset; a line is only read once its valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[index]  <= fill_tag;
      data_mem[index] <= fill_data;
    end else if (store_en) begin
      data_mem[index] <= store_data;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache controller for the MEM stage: same-cycle
// hits, stall while dirty victims are written back and missing lines filled.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_LINES  = 4,
  parameter int LINE_BYTES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_r_en,
  input  logic                    mem_w_en,
  input  logic                    is_byte,
  input  logic [31:0]             addr,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata,
  output logic                    block_pipe_data_cache,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [31:0]             mem_addr,
  output logic [LINE_BYTES*8-1:0] mem_wline,
  input  logic [LINE_BYTES*8-1:0] mem_rline,
  input  logic                    mem_ready
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 32 - OFFSET_W - IDX_W;

  state_t state;
  state_t next_state;

  logic [IDX_W-1:0]    index;
  logic [TAG_W-1:0]    tag;
  logic [OFFSET_W-1:0] offset;
  logic                access;
  logic                hit;

  logic                rd_valid;
  logic                rd_dirty;
  logic [TAG_W-1:0]    rd_tag;
  logic [LINE_W-1:0]   rd_data;
  logic                fill_en;
  logic                store_en;
  logic                clean_en;

  assign index  = IDX_W'(get_index(addr, NUM_LINES));
  assign tag    = TAG_W'(get_tag(addr, NUM_LINES));
  assign offset = addr[OFFSET_W-1:0];
  assign access = mem_r_en | mem_w_en;
  assign hit    = rd_valid && (rd_tag == tag);

  assign block_pipe_data_cache = access & ((state != IDLE) | !hit);

  dcache_line_store #(
    .NUM_LINES(NUM_LINES),
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W)
  ) u_line_store (
    .clk       (clk),
    .reset     (reset),
    .index     (index),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .fill_en   (fill_en),
    .fill_tag  (tag),
    .fill_data (mem_rline),
    .store_en  (store_en),
    .store_data(merge_store(rd_data, offset, wdata, is_byte)),
    .clean_en  (clean_en)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (access && !hit) next_state = (rd_valid && rd_dirty) ? WB : FILL;
      WB:   if (mem_ready) next_state = FILL;
      FILL: if (mem_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Array writes are suppressed while reset is high so an aborted fill never installs.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wline = '0;
    fill_en   = 1'b0;
    store_en  = 1'b0;
    clean_en  = 1'b0;
    case (state)
      IDLE: store_en = mem_w_en && hit && !reset;
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {rd_tag, index, 4'b0000};
        mem_wline = rd_data;
        clean_en  = mem_ready && !reset;
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = {addr[31:OFFSET_W], 4'b0000};
        fill_en  = mem_ready && !reset;
      end
      default: ;
    endcase
  end

  always_comb begin
    rdata = '0;
    if (mem_r_en && hit && state == IDLE) begin
      if (is_byte)
        rdata = {24'b0, rd_data[{offset, 3'b000} +: 8]};
      else
        rdata = rd_data[{offset[3:2], 5'b00000} +: 32];
    end
  end

endmodule
